trap_sequencer: RTL

Multi-cycle trap controller for the single-cycle RV32 core.
- Watches the exception flags raised by the datapath.
- Freezes the PC and suppresses commit of the faulting instruction.
- Writes uepc, ucause and utval into the CSR file over successive cycles through the single CSR write port.
- Redirects the PC to utvec.
- Sits between the control unit and the datapath CSR/PC multiplexers.

---
 rtl/trap_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// Multi-cycle trap controller: freezes the PC, writes uepc/ucause(/utval) through the
// single CSR port, then redirects to utvec. Optional macro TRAP_UTVAL_EN adds the utval write.
module trap_sequencer #(
    parameter logic [6:0] UEPC_NUM   = 7'h41,
    parameter logic [6:0] UCAUSE_NUM = 7'h42,
    parameter logic [6:0] UTVAL_NUM  = 7'h43,
    parameter int         CNT_W      = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iPcMisaligned,
    input  logic             iOutText,
    input  logic             iIllegal,
    input  logic             iEcall,
    input  logic             iMemRead,
    input  logic             iMemWrite,
    input  logic             iExcLoad,
    input  logic             iExcStore,
    input  logic             iOutData,
    input  logic [31:0]      iPC,
    input  logic [31:0]      iInstr,
    input  logic [31:0]      iBadAddr,
    input  logic [31:0]      iUtvec,
    output logic             oHoldPC,
    output logic             oKill,
    output logic             oCSRWrite,
    output logic [6:0]       oCSRNum,
    output logic [31:0]      oCSRData,
    output logic             oRedirect,
    output logic [31:0]      oRedirectPC,
    output logic             oBusy,
    output logic [3:0]       oCause,
    output logic [CNT_W-1:0] oTrapCount
);

`ifdef TRAP_UTVAL_EN
    typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, REDIRECT} state_t;
`else
    typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, REDIRECT} state_t;
`endif

    state_t      state;
    logic        exc_any;
    logic [3:0]  cause_nx;
    logic [3:0]  cause_r;
    logic        hold_r;
    logic        kill_r;
    logic        trap_now;

    // Priority encoder over the datapath flags; an out-of-segment address only
    // counts when the instruction actually accesses memory.
    always_comb begin
        exc_any  = 1'b1;
        cause_nx = 4'd0;
        if (iPcMisaligned)                 cause_nx = 4'd0;
        else if (iOutText)                 cause_nx = 4'd1;
        else if (iIllegal)                 cause_nx = 4'd2;
        else if (iEcall)                   cause_nx = 4'd8;
        else if (iExcStore && iMemWrite)   cause_nx = 4'd6;
        else if (iExcLoad && iMemRead)     cause_nx = 4'd4;
        else if (iOutData && iMemWrite)    cause_nx = 4'd7;
        else if (iOutData && iMemRead)     cause_nx = 4'd5;
        else                               exc_any  = 1'b0;
    end

`ifdef TRAP_UTVAL_EN
    logic [31:0] tval_nx;
    logic [31:0] tval_r;

    always_comb begin
        tval_nx = 32'd0;
        case (cause_nx)
            4'd0, 4'd1:             tval_nx = iPC;
            4'd2:                   tval_nx = iInstr;
            4'd4, 4'd5, 4'd6, 4'd7: tval_nx = iBadAddr;
            default:                tval_nx = 32'd0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^iUtvec[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{iInstr, iBadAddr, iUtvec[1:0]};
`endif

    assign trap_now = (state == IDLE) && exc_any;

    // The faulting instruction is held and killed in the detection cycle itself.
    assign oHoldPC     = ~iRST & (trap_now | hold_r);
    assign oKill       = ~iRST & (trap_now | kill_r);
    assign oRedirectPC = (oRedirect && !iRST) ? {iUtvec[31:2], 2'b00} : 32'd0;
    assign oCause      = cause_r;

    logic [31:0] pc_r;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= IDLE;
            cause_r    <= 4'd0;
            pc_r       <= 32'd0;
`ifdef TRAP_UTVAL_EN
            tval_r     <= 32'd0;
`endif
            hold_r     <= 1'b0;
            kill_r     <= 1'b0;
            oCSRWrite  <= 1'b0;
            oCSRNum    <= 7'd0;
            oCSRData   <= 32'd0;
            oRedirect  <= 1'b0;
            oBusy      <= 1'b0;
            oTrapCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc_any) begin
                        state     <= W_EPC;
                        cause_r   <= cause_nx;
                        pc_r      <= iPC;
`ifdef TRAP_UTVAL_EN
                        tval_r    <= tval_nx;
`endif
                        hold_r    <= 1'b1;
                        kill_r    <= 1'b1;
                        oBusy     <= 1'b1;
                        oCSRWrite <= 1'b1;
                        oCSRNum   <= UEPC_NUM;
                        oCSRData  <= iPC;
                    end
                end
                W_EPC: begin
                    state    <= W_CAUSE;
                    oCSRNum  <= UCAUSE_NUM;
                    oCSRData <= {28'd0, cause_r};
                end
`ifdef TRAP_UTVAL_EN
                W_CAUSE: begin
                    state    <= W_TVAL;
                    oCSRNum  <= UTVAL_NUM;
                    oCSRData <= tval_r;
                end
                W_TVAL: begin
                    state     <= REDIRECT;
                    oCSRWrite <= 1'b0;
                    oCSRNum   <= 7'd0;
                    oCSRData  <= 32'd0;
                    oRedirect <= 1'b1;
                    hold_r    <= 1'b0;
                end
`else
                W_CAUSE: begin
                    state     <= REDIRECT;
                    oCSRWrite <= 1'b0;
                    oCSRNum   <= 7'd0;
                    oCSRData  <= 32'd0;
                    oRedirect <= 1'b1;
                    hold_r    <= 1'b0;
                end
`endif
                REDIRECT: begin
                    state      <= IDLE;
                    oRedirect  <= 1'b0;
                    kill_r     <= 1'b0;
                    oBusy      <= 1'b0;
                    oTrapCount <= oTrapCount + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    state     <= IDLE;
                    hold_r    <= 1'b0;
                    kill_r    <= 1'b0;
                    oCSRWrite <= 1'b0;
                    oCSRNum   <= 7'd0;
                    oCSRData  <= 32'd0;
                    oRedirect <= 1'b0;
                    oBusy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
